// File: rtl/conv_ibuf_feeder_pkg.sv
// conv_pkg: state type and sizing helpers shared by the conv input feeder.
// Counter widths never drop below one bit, so degenerate dimensions still elaborate.
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE
   } feed_state_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int window_count(input int img, input int k);
      return (img - k + 1) * (img - k + 1);
   endfunction

endpackage

// File: rtl/conv_ibuf_feeder_if.sv
// Upstream beat handshake into the conv input feeder.
// Channel-serial: one activation value per accepted beat.
interface conv_ibuf_feeder_if #(
   parameter int DATA_SIZE = 8
);
   logic                 i_valid;
   logic                 o_ready_up;
   logic [DATA_SIZE-1:0] i_data;

   modport master (
      output i_valid,
      output i_data,
      input  o_ready_up
   );

   modport slave (
      input  i_valid,
      input  i_data,
      output o_ready_up
   );
endinterface

// File: rtl/conv_ibuf_feeder_pos_counter.sv
// conv_pos_counter: channel/column/row position of the incoming pixel stream.
// Flags describe the pixel currently being filled, before it advances.
module conv_pos_counter
   import conv_pkg::*;
#(
   parameter int IMG_DIM        = 28,
   parameter int KERNEL_DIM     = 3,
   parameter int INPUT_CHANNELS = 2,
   localparam int CW            = cnt_w(INPUT_CHANNELS),
   localparam int PW            = cnt_w(IMG_DIM)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   input  logic          clr,
   output logic [CW-1:0] ch,
   output logic          pix_done,
   output logic          window_valid,
   output logic          last_pixel
);

   localparam logic [CW-1:0] CH_LAST  = CW'(INPUT_CHANNELS - 1);
   localparam logic [PW-1:0] POS_LAST = PW'(IMG_DIM - 1);
   localparam logic [PW-1:0] WIN_MIN  = PW'(KERNEL_DIM - 1);

   logic [PW-1:0] col;
   logic [PW-1:0] row;

   assign pix_done     = adv && (ch == CH_LAST);
   assign window_valid = (row >= WIN_MIN) && (col >= WIN_MIN);
   assign last_pixel   = (row == POS_LAST) && (col == POS_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch  <= '0;
         col <= '0;
         row <= '0;
      end else if (clr) begin
         ch  <= '0;
         col <= '0;
         row <= '0;
      end else if (adv) begin
         if (ch == CH_LAST) begin
            ch <= '0;
            // Raster advance; row also wraps so the frame ends at (0,0)
            if (col == POS_LAST) begin
               col <= '0;
               row <= (row == POS_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end else begin
            ch <= ch + 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_ibuf_feeder.sv
// conv_ibuf_feeder: writes a channel-serial pixel stream into the conv input
// buffer and starts the layer each time a full stride-1 window is resident.
module conv_ibuf_feeder
   import conv_pkg::*;
#(
   parameter int DATA_SIZE      = 8,
   parameter int IMG_DIM        = 28,
   parameter int KERNEL_DIM     = 3,
   parameter int INPUT_CHANNELS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   conv_ibuf_feeder_if.slave         up,
   output logic [INPUT_CHANNELS-1:0] o_ibuf_we,
   output logic [DATA_SIZE-1:0]      o_ibuf_wr_data [INPUT_CHANNELS],
   output logic                      o_start,
   input  logic                      i_layer_ready,
   output logic                      o_frame_done,
   output logic                      o_busy
);

   localparam int CW = cnt_w(INPUT_CHANNELS);

   feed_state_e   state;
   logic          ready_q;
   logic          issue_wait;
   logic          win_last;
   logic          accept;
   logic          frame_clr;
   logic [CW-1:0] ch;
   logic          pix_done;
   logic          window_valid;
   logic          last_pixel;

   assign up.o_ready_up = ready_q;
   assign accept        = up.i_valid && ready_q;
   assign frame_clr     = (state == WAIT_DONE) && i_layer_ready && win_last;

   conv_pos_counter #(
      .IMG_DIM        (IMG_DIM),
      .KERNEL_DIM     (KERNEL_DIM),
      .INPUT_CHANNELS (INPUT_CHANNELS)
   ) u_pos (
      .clk          (clk),
      .rst          (rst),
      .adv          (accept),
      .clr          (frame_clr),
      .ch           (ch),
      .pix_done     (pix_done),
      .window_valid (window_valid),
      .last_pixel   (last_pixel)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         ready_q      <= 1'b0;
         issue_wait   <= 1'b0;
         win_last     <= 1'b0;
         o_ibuf_we    <= '0;
         o_start      <= 1'b0;
         o_frame_done <= 1'b0;
         o_busy       <= 1'b0;
         for (int i = 0; i < INPUT_CHANNELS; i++) begin
            o_ibuf_wr_data[i] <= '0;
         end
      end else begin
         o_start      <= 1'b0;
         o_frame_done <= 1'b0;
         for (int i = 0; i < INPUT_CHANNELS; i++) begin
            o_ibuf_we[i] <= accept && (ch == CW'(i));
            if (accept && (ch == CW'(i))) begin
               o_ibuf_wr_data[i] <= up.i_data;
            end
         end
         unique case (state)
            IDLE, FILL: begin
               ready_q <= 1'b1;
               if (accept) begin
                  o_busy <= 1'b1;
                  if (pix_done && window_valid) begin
                     state      <= ISSUE;
                     ready_q    <= 1'b0;
                     issue_wait <= 1'b1;
                     win_last   <= last_pixel;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            ISSUE: begin
               // First ISSUE cycle lets the window's final write land
               issue_wait <= 1'b0;
               if (!issue_wait && i_layer_ready) begin
                  o_start <= 1'b1;
                  state   <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (!i_layer_ready) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (i_layer_ready) begin
                  ready_q <= 1'b1;
                  if (win_last) begin
                     o_frame_done <= 1'b1;
                     o_busy       <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
